// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder (one per DVI channel).
// It finds symbol alignment in the raw deserializer words by hunting for runs
// of control tokens, then decodes each aligned symbol to pixel data or control.
// Optional build macro: TMDS_SLIP_OUT_EN. When it is defined, the internal
// window shifter is removed and alignment is instead requested from the
// deserializer through single-cycle slip pulses.
module tmds_decoder #(
   parameter int LOCK_RUN    = 16,
   parameter int SEARCH_WAIT = 4096,
   parameter int LOSS_WAIT   = 8192
) (
   input  logic       clk_pix,
   input  logic       rst_pix_n,
   input  logic [9:0] sym_in,
   output logic       de,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic       locked,
   output logic [3:0] offset,
   output logic       slip
);

   localparam int RUN_W   = $clog2(LOCK_RUN + 1);
   localparam int TMR_MAX = (SEARCH_WAIT > LOSS_WAIT) ? SEARCH_WAIT : LOSS_WAIT;
   localparam int TMR_W   = $clog2(TMR_MAX);

   localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(LOCK_RUN);
   localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(LOCK_RUN - 1);
   localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_WAIT - 1);
   localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_WAIT - 1);

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Returns {hit, value}; value is meaningful only when hit is set.
   function automatic logic [2:0] match_token(input logic [9:0] s);
      logic [2:0] r;
      case (s)
         TOK_00:  r = 3'b100;
         TOK_01:  r = 3'b101;
         TOK_10:  r = 3'b110;
         TOK_11:  r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
   function automatic logic [7:0] decode_data(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
      return d;
   endfunction

   logic [9:0]       sym_p0;      // previous raw word
   logic [9:0]       sym_al_p1;   // aligned symbol
   logic [9:0]       win;
   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] run_cnt;
   logic [TMR_W-1:0] timer;
   logic [1:0]       ign_cnt;
   logic             tok_hit;
   logic [1:0]       tok_val;
   logic             tok_run;
   logic             run_done;
   logic             seek_step;
   logic             loss_timeout;
   logic [7:0]       dec_d;

`ifdef TMDS_SLIP_OUT_EN
   // The deserializer does the shifting; the window is simply the last word.
   assign win    = sym_p0;
   assign offset = 4'd0;

   // One-cycle bitslip request on every search timeout.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) slip <= 1'b0;
      else            slip <= seek_step;
   end
`else
   logic [19:0] cat;
   assign cat  = {sym_in, sym_p0};
   assign slip = 1'b0;

   // Pick the 10-bit window starting 'offset' bits into the two-word history.
   always_comb begin
      win = cat[9:0];
      case (offset)
         4'd0:    win = cat[9:0];
         4'd1:    win = cat[10:1];
         4'd2:    win = cat[11:2];
         4'd3:    win = cat[12:3];
         4'd4:    win = cat[13:4];
         4'd5:    win = cat[14:5];
         4'd6:    win = cat[15:6];
         4'd7:    win = cat[16:7];
         4'd8:    win = cat[17:8];
         4'd9:    win = cat[18:9];
         default: win = cat[19:10];
      endcase
   end

   // Advance the bit offset on each search timeout, wrapping 9 -> 0.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n)     offset <= 4'd0;
      else if (seek_step) offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
   end
`endif

   // ---- stage 0 -> 1: capture raw word history and the aligned window
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         sym_p0    <= 10'd0;
         sym_al_p1 <= 10'd0;
      end else begin
         sym_p0    <= sym_in;
         sym_al_p1 <= win;
      end
   end

   assign {tok_hit, tok_val} = match_token(sym_al_p1);
   assign dec_d    = decode_data(sym_al_p1);
   // Tokens seen just after an offset change come from the old alignment.
   assign tok_run  = tok_hit && (ign_cnt == 2'd0);
   assign run_done = tok_run && (run_cnt == RUN_LAST);

   // Search/lock state register.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) state <= ST_SEARCH;
      else            state <= state_nxt;
   end

   // Next-state logic; a completed run always beats a timeout.
   always_comb begin
      state_nxt    = state;
      seek_step    = 1'b0;
      loss_timeout = 1'b0;
      case (state)
         ST_SEARCH: begin
            if (run_done)                  state_nxt = ST_LOCKED;
            else if (timer == SEARCH_LAST) seek_step = 1'b1;
         end
         ST_LOCKED: begin
            if (!run_done && (timer == LOSS_LAST)) begin
               state_nxt    = ST_SEARCH;
               loss_timeout = 1'b1;
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

   // Consecutive-token run length, saturating so a run completes only once.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n)     run_cnt <= '0;
      else if (seek_step) run_cnt <= '0;
      else if (tok_run)   run_cnt <= (run_cnt == RUN_FULL) ? run_cnt : run_cnt + 1'b1;
      else                run_cnt <= '0;
   end

   // Cycles since the last completed run, state change or offset change.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n)                            timer <= '0;
      else if (run_done || seek_step || loss_timeout) timer <= '0;
      else                                       timer <= timer + 1'b1;
   end

   // Blanking window covering the two symbols still in flight after a step.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n)             ign_cnt <= 2'd0;
      else if (seek_step)         ign_cnt <= 2'd2;
      else if (ign_cnt != 2'd0)   ign_cnt <= ign_cnt - 2'd1;
   end

   // ---- stage 1 -> 2: decoded outputs; ctrl keeps its value through data
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         de     <= 1'b0;
         data   <= 8'd0;
         ctrl   <= 2'd0;
         locked <= 1'b0;
      end else begin
         locked <= (state == ST_LOCKED);
         if (state == ST_SEARCH) begin
            de   <= 1'b0;
            data <= 8'd0;
            ctrl <= 2'd0;
         end else if (tok_hit) begin
            de   <= 1'b0;
            data <= 8'd0;
            ctrl <= tok_val;
         end else begin
            de   <= 1'b1;
            data <= dec_d;
         end
      end
   end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: randomized bench for tmds_decoder with a serial-bitstream
// reference model plus directed checks at the interesting boundaries.
module tb_tmds_decoder;

   localparam int LOCK_RUN    = 16;
   localparam int SEARCH_WAIT = 4096;
   localparam int LOSS_WAIT   = 8192;
`ifdef TMDS_SLIP_OUT_EN
   localparam bit SLIP_BUILD = 1'b1;
`else
   localparam bit SLIP_BUILD = 1'b0;
`endif

   logic       clk_pix = 1'b0;
   logic       rst_pix_n;
   logic [9:0] sym_in;
   logic       de;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       locked;
   logic [3:0] offset;
   logic       slip;

   always #5 clk_pix = ~clk_pix;

   tmds_decoder #(
      .LOCK_RUN(LOCK_RUN),
      .SEARCH_WAIT(SEARCH_WAIT),
      .LOSS_WAIT(LOSS_WAIT)
   ) dut (
      .clk_pix(clk_pix),
      .rst_pix_n(rst_pix_n),
      .sym_in(sym_in),
      .de(de),
      .data(data),
      .ctrl(ctrl),
      .locked(locked),
      .offset(offset),
      .slip(slip)
   );

   int total = 0;
   int bad   = 0;

   logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};
   logic [7:0] dec_tab [2][256];

   // Reference model: the received words as one serial bitstream.
   logic [9:0] hist[$];
   logic [9:0] m_al;
   int         m_state, m_off, m_run, m_timer, m_ign;
   logic       m_de, m_locked, m_slip;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;

   function automatic int tok_index(input logic [9:0] s);
      for (int k = 0; k < 4; k++) if (s == tok_tab[k]) return k;
      return -1;
   endfunction

   function automatic logic stream_bit(input int p);
      logic [9:0] w;
      w = hist[p / 10];
      return w[p % 10];
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      do w = 10'($urandom); while (tok_index(w) >= 0);
      return w;
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back(10'd0);
      m_al = 10'd0; m_state = 0; m_off = 0; m_run = 0; m_timer = 0; m_ign = 0;
      m_de = 1'b0; m_data = 8'd0; m_ctrl = 2'd0; m_locked = 1'b0; m_slip = 1'b0;
   endtask

   task automatic model_edge(input logic [9:0] w);
      int n, t, base;
      logic [9:0] al_new;
      logic [7:0] q;
      bit counted, done, tmo_s, tmo_l;
      n = hist.size() - 1;
      hist.push_back(w);
      base = 10 * n + (SLIP_BUILD ? 0 : m_off);
      for (int j = 0; j < 10; j++) al_new[j] = stream_bit(base + j);
      t       = tok_index(m_al);
      counted = (t >= 0) && (m_ign == 0);
      done    = counted && (m_run == LOCK_RUN - 1);
      tmo_s   = (m_state == 0) && !done && (m_timer == SEARCH_WAIT - 1);
      tmo_l   = (m_state == 1) && !done && (m_timer == LOSS_WAIT - 1);
      m_locked = (m_state == 1);
      if (m_state == 0) begin
         m_de = 1'b0; m_data = 8'd0; m_ctrl = 2'd0;
      end else if (t >= 0) begin
         m_de = 1'b0; m_data = 8'd0; m_ctrl = 2'(t);
      end else begin
         q = m_al[9] ? ~m_al[7:0] : m_al[7:0];
         m_de = 1'b1; m_data = dec_tab[m_al[8]][q];
      end
      m_slip  = SLIP_BUILD && tmo_s;
      m_run   = tmo_s ? 0 : (counted ? ((m_run < LOCK_RUN) ? m_run + 1 : m_run) : 0);
      m_ign   = tmo_s ? 2 : ((m_ign > 0) ? m_ign - 1 : 0);
      if (tmo_s && !SLIP_BUILD) m_off = (m_off + 1) % 10;
      if (done) m_state = 1;
      else if (tmo_l) m_state = 0;
      m_timer = (done || tmo_s || tmo_l) ? 0 : m_timer + 1;
      m_al    = al_new;
   endtask

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [9:0] w);
      sym_in = w;
      @(posedge clk_pix);
      model_edge(w);
      #1;
      check("model", {de, data, ctrl, locked, offset, slip},
            {m_de, m_data, m_ctrl, m_locked, 4'(m_off), m_slip});
   endtask

   task automatic apply_reset();
      #2;
      rst_pix_n = 1'b0;
      #1;
      check("reset_now", {de, data, ctrl, locked, offset, slip}, 17'd0);
      repeat (3) @(posedge clk_pix);
      #1;
      check("reset_held", {de, data, ctrl, locked, offset, slip}, 17'd0);
      #2;
      rst_pix_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] dv, qm;
      logic [9:0] s, s_prev;
      int tk, len, cyc, pulses, first_pulse, gap;
      bit got_lock;

      for (int d = 0; d < 256; d++) begin
         for (int m = 0; m < 2; m++) begin
            dv = 8'(d);
            qm[0] = dv[0];
            for (int i = 1; i < 8; i++) qm[i] = m ? (qm[i-1] ^ dv[i]) : ~(qm[i-1] ^ dv[i]);
            dec_tab[m][qm] = dv;
         end
      end

      rst_pix_n = 1'b1;
      sym_in    = 10'd0;
      model_reset();
      apply_reset();

      // Aligned lock at offset 0
      for (int i = 0; i < 18; i++) drive(tok_tab[0]);
      check("lock_not_yet", 17'(locked), 17'd0);
      drive(tok_tab[0]);
      check("lock_rise", 17'({de, ctrl, locked}), 17'(4'b0001));
      drive(tok_tab[0]);
      drive(10'b0100000000);
      drive(10'b1011111111);
      drive(tok_tab[0]);
      check("data_00", 17'({de, data, ctrl}), 17'({1'b1, 8'h00, 2'b00}));
      drive(tok_tab[0]);
      check("data_fe", 17'({de, data, ctrl}), 17'({1'b1, 8'hFE, 2'b00}));

      // Random blanking/active traffic while locked
      for (int l = 0; l < 12; l++) begin
         tk  = $urandom_range(3, 0);
         len = $urandom_range(40, 16);
         for (int i = 0; i < len; i++) drive(tok_tab[tk]);
         len = $urandom_range(30, 5);
         for (int i = 0; i < len; i++) drive(rand_data());
      end
      for (int i = 0; i < 20; i++) drive(tok_tab[1]);
      check("still_locked", 17'({locked, ctrl}), 17'(3'b101));

      // Asynchronous reset in the middle of lock
      apply_reset();
      for (int i = 0; i < 10; i++) drive(tok_tab[2]);
      check("no_relock_short", 17'(locked), 17'd0);
      for (int i = 0; i < 20; i++) drive(tok_tab[3]);
      check("relock", 17'({locked, ctrl}), 17'(3'b111));

      // Loss of lock on data-only traffic
      for (int i = 0; i < LOSS_WAIT + 8; i++) drive(rand_data());
      check("loss", 17'({locked, de, offset}), 17'd0);

      // Runs one token short of a lock never lock; offset steps on timeout
      apply_reset();
      for (int n = 0; n < SEARCH_WAIT; n++) begin
         drive(((n % 20) < 15) ? tok_tab[0] : rand_data());
         if (n == SEARCH_WAIT - 2)
            check("short_before", 17'({locked, offset, slip}), 17'd0);
      end
      check("short_step", 17'({locked, offset, slip}),
            SLIP_BUILD ? 17'({1'b0, 4'd0, 1'b1}) : 17'({1'b0, 4'd1, 1'b0}));

`ifndef TMDS_SLIP_OUT_EN
      // Stream rotated by 3 bits: 100 tokens of blanking per 1500-cycle line
      apply_reset();
      s_prev   = 10'd0;
      tk       = 0;
      got_lock = 1'b0;
      cyc      = 0;
      while (cyc < 20000 && !got_lock) begin
         if ((cyc % 1500) == 0) tk = $urandom_range(3, 0);
         s = ((cyc % 1500) < 100) ? tok_tab[tk] : rand_data();
         drive({s[6:0], s_prev[9:7]});
         s_prev = s;
         if (cyc == SEARCH_WAIT - 1)     check("mis_off1", 17'(offset), 17'd1);
         if (cyc == 2 * SEARCH_WAIT - 1) check("mis_off2", 17'(offset), 17'd2);
         if (cyc == 3 * SEARCH_WAIT - 1) check("mis_off3", 17'(offset), 17'd3);
         got_lock = locked;
         cyc++;
      end
      check("mis_lock", 17'({locked, offset}), 17'({1'b1, 4'd3}));
      for (int i = 0; i < 1600; i++) begin
         if ((cyc % 1500) == 0) tk = $urandom_range(3, 0);
         s = ((cyc % 1500) < 100) ? tok_tab[tk] : rand_data();
         drive({s[6:0], s_prev[9:7]});
         s_prev = s;
         if ((cyc % 1500) == 50)
            check("mis_ctrl", 17'({de, ctrl, locked}), 17'({1'b0, 2'(tk), 1'b1}));
         cyc++;
      end
`else
      // Slip build: no tokens, so a slip pulse every search period
      apply_reset();
      pulses = 0;
      first_pulse = -1;
      gap = -1;
      for (int n = 0; n < 2 * SEARCH_WAIT + 8; n++) begin
         drive(rand_data());
         if (slip) begin
            if (pulses == 0) first_pulse = n;
            else if (pulses == 1) gap = n - first_pulse;
            pulses++;
         end
      end
      check("slip_count", 17'(pulses), 17'd2);
      check("slip_gap", 17'(gap), 17'(SEARCH_WAIT));
      check("slip_offset", 17'(offset), 17'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
